// File: rtl/wb_arb_nic_if.sv
// rtl/wb_arb_nic_if.sv - Wishbone master/slave signal bundle for wb_arb_nic
//
// Carries every per-master request/response signal and every shared
// slave-bus signal of the arbiter.
//   slave  modport : the arbiter's view (takes master requests and slave
//                    responses, drives grants/acks/errors and the slave bus)
//   master modport : the surrounding system's view (masters plus slaves)
// MASTERS, SEL_WIDTH, ADDR_WIDTH and DATA_WIDTH must match the arbiter.

interface wb_arb_nic_if #(
    parameter int MASTERS    = 2,
    parameter int SEL_WIDTH  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SLAVES = 2 ** SEL_WIDTH;
    localparam int SW     = DATA_WIDTH / 8;

    // master side
    logic [MASTERS-1:0]                 i_m_cyc;
    logic [MASTERS-1:0]                 i_m_stb;
    logic [MASTERS-1:0]                 i_m_we;
    logic [MASTERS-1:0][ADDR_WIDTH-1:0] i_m_adr;
    logic [MASTERS-1:0][DATA_WIDTH-1:0] i_m_dat;
    logic [MASTERS-1:0][SW-1:0]         i_m_sel;
    logic [DATA_WIDTH-1:0]              o_m_dat;
    logic [MASTERS-1:0]                 o_m_ack;
    logic [MASTERS-1:0]                 o_m_err;
    logic [MASTERS-1:0]                 o_m_gnt;

    // shared slave side
    logic [ADDR_WIDTH-1:0]              o_s_adr;
    logic [DATA_WIDTH-1:0]              o_s_dat;
    logic                               o_s_we;
    logic [SW-1:0]                      o_s_sel;
    logic                               o_s_stb;
    logic                               o_s_cyc;
    logic [SLAVES-1:0]                  o_s_dev;
    logic [SLAVES-1:0][DATA_WIDTH-1:0]  i_s_dat;
    logic [SLAVES-1:0]                  i_s_ack;
    logic [SLAVES-1:0]                  i_s_err;

    modport slave (
        input  i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_m_sel,
        input  i_s_dat, i_s_ack, i_s_err,
        output o_m_dat, o_m_ack, o_m_err, o_m_gnt,
        output o_s_adr, o_s_dat, o_s_we, o_s_sel, o_s_stb, o_s_cyc, o_s_dev
    );

    modport master (
        output i_m_cyc, i_m_stb, i_m_we, i_m_adr, i_m_dat, i_m_sel,
        output i_s_dat, i_s_ack, i_s_err,
        input  o_m_dat, o_m_ack, o_m_err, o_m_gnt,
        input  o_s_adr, o_s_dat, o_s_we, o_s_sel, o_s_stb, o_s_cyc, o_s_dev
    );
endinterface

// File: rtl/wb_arb_nic.sv
// rtl/wb_arb_nic.sv - round-robin Wishbone arbiter with address decode and timeout
//
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_reset : asynchronous active-high reset
//   bus     : wb_arb_nic_if.slave - per-master cyc/stb/we/adr/dat/sel in,
//             ack/err/gnt and broadcast read data out; shared slave bus out
//             with one-hot device select, per-slave dat/ack/err in
//
// A granted master keeps the bus for as long as it holds cyc. The top
// SEL_WIDTH address bits pick the slave. Unmapped accesses and slave
// timeouts produce a one-cycle registered error.

module wb_arb_nic #(
    parameter int                      MASTERS    = 2,
    parameter int                      SEL_WIDTH  = 4,
    parameter int                      ADDR_WIDTH = 32,
    parameter int                      DATA_WIDTH = 32,
    parameter logic [2**SEL_WIDTH-1:0] SLAVE_MASK = '1,
    parameter int                      TIMEOUT    = 255
) (
    input  logic         i_clk,
    input  logic         i_reset,
    wb_arb_nic_if.slave  bus
);
    localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   lg_q, lg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_pending_q, err_pending_d;

    logic                 busy;
    logic                 cyc_g;
    logic                 stb_g;
    logic [SEL_WIDTH-1:0] dev;
    logic                 mapped;
    logic                 s_stb;
    logic                 s_ack;
    logic                 s_err;
    logic                 found;
    logic [GW-1:0]        idx;

    always_comb begin
        busy   = (state_q == BUSY);
        cyc_g  = bus.i_m_cyc[g_q];
        stb_g  = bus.i_m_stb[g_q];
        dev    = bus.i_m_adr[g_q][ADDR_WIDTH-1 -: SEL_WIDTH];
        mapped = SLAVE_MASK[dev];
        // the registered-error cycle hides the strobe so the slave cannot
        // answer in the same cycle the master is told about the error
        s_stb  = busy & stb_g & mapped & ~err_pending_q;
        s_err  = bus.i_s_err[dev] & s_stb;
        // a slave raising ack and err together is reported as an error only
        s_ack  = bus.i_s_ack[dev] & s_stb & ~s_err;
    end

    // slave bus and master responses
    always_comb begin
        bus.o_s_adr = bus.i_m_adr[g_q];
        bus.o_s_dat = bus.i_m_dat[g_q];
        bus.o_s_we  = bus.i_m_we[g_q];
        bus.o_s_sel = bus.i_m_sel[g_q];
        bus.o_s_cyc = busy & cyc_g;
        bus.o_s_stb = s_stb;
        bus.o_s_dev = '0;
        if (busy && cyc_g && mapped) begin
            bus.o_s_dev[dev] = 1'b1;
        end
        bus.o_m_dat = bus.i_s_dat[dev];
        bus.o_m_gnt = '0;
        bus.o_m_ack = '0;
        bus.o_m_err = '0;
        if (busy) begin
            bus.o_m_gnt[g_q] = 1'b1;
            bus.o_m_ack[g_q] = s_ack;
            // a pending registered error is dropped once the master lets go
            bus.o_m_err[g_q] = s_err | (err_pending_q & cyc_g);
        end
    end

    // next state
    always_comb begin
        state_d       = state_q;
        g_d           = g_q;
        lg_d          = lg_q;
        cnt_d         = cnt_q;
        err_pending_d = 1'b0;
        found         = 1'b0;
        idx           = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // search starts just after the last winner, wrapping around
                for (int i = 1; i <= MASTERS; i++) begin
                    idx = GW'((int'(lg_q) + i) % MASTERS);
                    if (!found && bus.i_m_cyc[idx]) begin
                        found   = 1'b1;
                        g_d     = idx;
                        lg_d    = idx;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!cyc_g) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (stb_g && !mapped) begin
                    // first cycle of an unmapped strobe arms the error; the
                    // error cycle itself does not re-arm it
                    cnt_d         = '0;
                    err_pending_d = ~err_pending_q;
                end else if (s_stb && !s_ack && !s_err) begin
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        cnt_d         = '0;
                        err_pending_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= IDLE;
            g_q           <= '0;
            lg_q          <= GW'(MASTERS - 1);
            cnt_q         <= '0;
            err_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            g_q           <= g_d;
            lg_q          <= lg_d;
            cnt_q         <= cnt_d;
            err_pending_q <= err_pending_d;
        end
    end
endmodule

// File: tb/tb_wb_arb_nic.sv
// tb/tb_wb_arb_nic.sv - scoreboard bench for wb_arb_nic

module tb_wb_arb_nic;
    localparam int MASTERS   = 2;
    localparam int SEL_WIDTH = 4;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int SLAVES    = 16;
    localparam int TIMEOUT   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arb_nic_if #(.MASTERS(MASTERS), .SEL_WIDTH(SEL_WIDTH),
                    .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_arb_nic #(
        .MASTERS(MASTERS), .SEL_WIDTH(SEL_WIDTH), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .SLAVE_MASK(16'h0003), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus)
    );

    typedef struct {
        int            m;
        bit            err;
        bit            chk_dat;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int            s_lat [SLAVES];
    bit            s_err_mode [SLAVES];
    logic [DW-1:0] s_rdat [SLAVES];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // slave model: answers in the s_lat-th strobe cycle (0 = never)
    initial begin : slave_model
        int s_wait;
        int d;
        bus.i_s_ack = '0;
        bus.i_s_err = '0;
        bus.i_s_dat = '0;
        s_wait = 0;
        forever begin
            @(posedge clk);
            #3;
            for (int i = 0; i < SLAVES; i++) bus.i_s_dat[i] = s_rdat[i];
            if (rst) begin
                bus.i_s_ack = '0;
                bus.i_s_err = '0;
                s_wait = 0;
            end else if ((|bus.i_s_ack) || (|bus.i_s_err)) begin
                bus.i_s_ack = '0;
                bus.i_s_err = '0;
                s_wait = 0;
            end else if (bus.o_s_stb) begin
                d = 0;
                for (int i = 0; i < SLAVES; i++) if (bus.o_s_dev[i]) d = i;
                s_wait++;
                if (s_lat[d] != 0 && s_wait >= s_lat[d]) begin
                    if (s_err_mode[d]) bus.i_s_err[d] = 1'b1;
                    else               bus.i_s_ack[d] = 1'b1;
                end
            end else begin
                s_wait = 0;
            end
        end
    end

    // scoreboard consumer: every ack/err must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && ((|bus.o_m_ack) || (|bus.o_m_err))) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {bus.o_m_ack, bus.o_m_err}, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_ack", bus.o_m_ack, e.err ? 64'd0 : (64'd1 << e.m));
                chk("sb_err", bus.o_m_err, e.err ? (64'd1 << e.m) : 64'd0);
                if (e.chk_dat) chk("sb_rdata", bus.o_m_dat, e.dat);
            end
        end
    end

    task automatic m_raise(input int m, input logic [AW-1:0] adr, input logic we,
                           input logic [DW-1:0] dat);
        bus.i_m_cyc[m] = 1'b1;
        bus.i_m_stb[m] = 1'b1;
        bus.i_m_we[m]  = we;
        bus.i_m_adr[m] = adr;
        bus.i_m_dat[m] = dat;
        bus.i_m_sel[m] = '1;
    endtask

    task automatic m_drop(input int m);
        @(posedge clk);
        #1;
        bus.i_m_cyc[m] = 1'b0;
        bus.i_m_stb[m] = 1'b0;
        bus.i_m_we[m]  = 1'b0;
    endtask

    // push the expected response, then wait (bounded) until master m sees it
    task automatic xfer_wait(input int m, input logic we, input logic [DW-1:0] wdat,
                             input bit exp_err, input logic [DW-1:0] exp_dat,
                             input int exp_gnt_n);
        exp_t e;
        int   n;
        int   gnt_n;
        bit   hit;
        e.m = m; e.err = exp_err; e.chk_dat = !we && !exp_err; e.dat = exp_dat;
        sb_q.push_back(e);
        n = 0; gnt_n = 0; hit = 0;
        while (!hit && n < 40) begin
            @(negedge clk);
            n++;
            if (gnt_n == 0 && bus.o_m_gnt[m]) gnt_n = n;
            if (bus.o_m_ack[m] || bus.o_m_err[m]) begin
                hit = 1;
                if (we && bus.o_m_ack[m]) chk("wr_data", bus.o_s_dat, wdat);
            end
        end
        if (!hit) chk("xfer_no_response", 0, 1);
        if (exp_gnt_n != 0) chk("gnt_cycle", gnt_n, exp_gnt_n);
    endtask

    task automatic do_xfer(input int m, input logic [AW-1:0] adr, input logic we,
                           input logic [DW-1:0] dat, input bit exp_err,
                           input logic [DW-1:0] exp_dat, input int exp_gnt_n);
        @(posedge clk);
        #1;
        m_raise(m, adr, we, dat);
        xfer_wait(m, we, dat, exp_err, exp_dat, exp_gnt_n);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, bus.o_m_gnt, 0);
        chk({tag, "_ack"}, bus.o_m_ack, 0);
        chk({tag, "_err"}, bus.o_m_err, 0);
        chk({tag, "_cyc"}, bus.o_s_cyc, 0);
        chk({tag, "_stb"}, bus.o_s_stb, 0);
        chk({tag, "_dev"}, bus.o_s_dev, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int cnt;
        bit seen;
        bus.i_m_cyc = '0; bus.i_m_stb = '0; bus.i_m_we = '0;
        bus.i_m_adr = '0; bus.i_m_dat = '0; bus.i_m_sel = '0;
        for (int i = 0; i < SLAVES; i++) begin
            s_lat[i] = 1;
            s_err_mode[i] = 0;
            s_rdat[i] = 32'hA500_0000 + i;
        end
        s_rdat[0] = 32'hDEAD_BEEF;

        // reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // single read, slave 0 answers after 2 strobe cycles
        s_lat[0] = 2;
        do_xfer(0, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);
        m_drop(0);
        s_lat[0] = 1;

        // round robin from reset
        pulse_reset();
        @(posedge clk);
        #1;
        m_raise(0, 32'h0000_0010, 1'b0, 32'h0);
        m_raise(1, 32'h1000_0000, 1'b0, 32'h0);
        xfer_wait(0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);
        m_drop(0);
        xfer_wait(1, 1'b0, 32'h0, 1'b0, s_rdat[1], 3);
        @(posedge clk);
        #1;
        m_raise(0, 32'h0000_0014, 1'b0, 32'h0);
        bus.i_m_cyc[1] = 1'b0;
        bus.i_m_stb[1] = 1'b0;
        xfer_wait(0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 3);
        m_drop(0);
        repeat (2) @(posedge clk);
        #1;
        m_raise(0, 32'h0000_0010, 1'b0, 32'h0);
        m_raise(1, 32'h1000_0010, 1'b0, 32'h0);
        xfer_wait(1, 1'b0, 32'h0, 1'b0, s_rdat[1], 2);
        m_drop(1);
        xfer_wait(0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 3);
        m_drop(0);

        // unmapped write: error exactly one cycle after the strobe is seen
        @(posedge clk);
        #1;
        m_raise(0, 32'h5000_0000, 1'b1, 32'h1234_5678);
        begin
            exp_t e;
            e.m = 0; e.err = 1; e.chk_dat = 0; e.dat = '0;
            sb_q.push_back(e);
        end
        @(negedge clk);
        @(negedge clk);
        chk("unmap_stb", bus.o_s_stb, 0);
        chk("unmap_dev", bus.o_s_dev, 0);
        chk("unmap_err_early", bus.o_m_err, 0);
        @(negedge clk);
        chk("unmap_err", bus.o_m_err, 2'b01);
        m_drop(0);
        @(negedge clk);
        chk("unmap_err_single", bus.o_m_err, 0);

        // timeout on a slave that never answers
        s_lat[1] = 0;
        @(posedge clk);
        #1;
        m_raise(0, 32'h1000_0000, 1'b0, 32'h0);
        begin
            exp_t e;
            e.m = 0; e.err = 1; e.chk_dat = 0; e.dat = '0;
            sb_q.push_back(e);
        end
        cnt = 0;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (bus.o_m_err[0]) begin
                seen = 1;
                chk("to_stb_cycles", cnt, TIMEOUT);
                chk("to_stb_low", bus.o_s_stb, 0);
                chk("to_no_ack", bus.o_m_ack, 0);
            end else if (bus.o_s_stb) begin
                cnt++;
            end
        end
        if (!seen) chk("to_no_error", 0, 1);
        m_drop(0);

        // ack arriving in the same cycle the timeout would fire wins
        s_lat[1] = TIMEOUT;
        do_xfer(0, 32'h1000_0004, 1'b0, 32'h0, 1'b0, s_rdat[1], 2);
        m_drop(0);
        s_lat[1] = 1;

        // slave error is passed through combinationally
        s_err_mode[0] = 1;
        do_xfer(1, 32'h0000_0020, 1'b0, 32'h0, 1'b1, 32'h0, 2);
        m_drop(1);
        s_err_mode[0] = 0;

        // bus lock: M1 does three writes while M0 waits
        do_xfer(1, 32'h1000_0000, 1'b1, 32'h1111_0001, 1'b0, 32'h0, 2);
        @(posedge clk);
        #1;
        m_raise(0, 32'h0000_0030, 1'b0, 32'h0);
        m_raise(1, 32'h1000_0004, 1'b1, 32'h1111_0002);
        xfer_wait(1, 1'b1, 32'h1111_0002, 1'b0, 32'h0, 0);
        chk("lock_gnt0_a", bus.o_m_gnt[0], 0);
        do_xfer(1, 32'h1000_0008, 1'b1, 32'h1111_0003, 1'b0, 32'h0, 0);
        chk("lock_gnt0_b", bus.o_m_gnt[0], 0);
        m_drop(1);
        xfer_wait(0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 3);
        m_drop(0);

        // asynchronous reset in the middle of a strobe
        s_lat[1] = 0;
        @(posedge clk);
        #1;
        m_raise(0, 32'h1000_0000, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        chk("pre_reset_stb", bus.o_s_stb, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        m_raise(1, 32'h1000_0000, 1'b0, 32'h0);
        #1;
        chk_all_zero("async_reset");
        sb_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", bus.o_m_gnt, 2'b00);
        @(negedge clk);
        chk("post_reset_gnt", bus.o_m_gnt, 2'b01);
        @(posedge clk);
        #1;
        bus.i_m_cyc = '0;
        bus.i_m_stb = '0;
        s_lat[1] = 1;

        repeat (3) @(negedge clk);
        chk("sb_left", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
